// File: rtl/jk_cmd_sequencer_if.sv
// Command push channel for jk_cmd_sequencer: valid/ready handshake carrying op, mask and repeat count.
interface jk_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_mask;
    logic [CNT_W-1:0] cmd_rep;

    modport master (output cmd_valid, cmd_op, cmd_mask, cmd_rep, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_rep, output cmd_ready);
endinterface

// File: rtl/jk_cmd_sequencer.sv
// Queues hold/reset/set/toggle commands and replays them as registered J/K vectors for a JK flip-flop bank,
// keeping a shadow copy of the expected flip-flop state.
module jk_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    jk_cmd_sequencer_if.slave cmd,
    output logic [WIDTH-1:0]  J,
    output logic [WIDTH-1:0]  K,
    output logic [WIDTH-1:0]  shadow_q,
    output logic              done,
    output logic              busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 + WIDTH + CNT_W;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, APPLY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d, shadow_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [EW-1:0]    fifo_q [DEPTH];
    logic [EW-1:0]    fifo_d [DEPTH];

    logic             push, pop, empty;
    logic [EW-1:0]    head;
    logic [1:0]       head_op;
    logic [WIDTH-1:0] head_mask;
    logic [CNT_W-1:0] head_rep;

    assign empty         = (count_q == '0);
    assign cmd.cmd_ready = clr & (count_q != FULL);
    assign push          = cmd.cmd_valid & cmd.cmd_ready;
    assign J             = j_q;
    assign K             = k_q;
    assign done          = (state_q == APPLY) && (remaining_q == '0);
    assign busy          = (state_q == APPLY) || !empty;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        j_d         = j_q;
        k_d         = k_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_d      = fifo_q;
        pop         = 1'b0;
        head        = fifo_q[rd_ptr_q];
        head_op     = head[EW-1 -: 2];
        head_mask   = head[CNT_W +: WIDTH];
        head_rep    = head[CNT_W-1:0];
        // JK next-state applied to the vector being driven now, matching what the flip-flops sample
        shadow_d    = (j_q & ~shadow_q) | (~k_q & shadow_q);

        if (push) begin
            fifo_d[wr_ptr_q] = {cmd.cmd_op, cmd.cmd_mask, cmd.cmd_rep};
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end

        case (state_q)
            IDLE: begin
                j_d = '0;
                k_d = '0;
                pop = !empty;
            end
            APPLY: begin
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end else if (!empty) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Popping on the final apply edge chains commands with no idle cycle between them
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            state_d     = APPLY;
            remaining_d = head_rep;
            j_d         = head_mask & {WIDTH{head_op[1]}};
            k_d         = head_mask & {WIDTH{head_op[0]}};
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            j_q         <= '0;
            k_q         <= '0;
            shadow_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            j_q         <= j_d;
            k_q         <= k_d;
            shadow_q    <= shadow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end
endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed testbench for jk_cmd_sequencer: each task drives one scenario and checks hand-computed values.
module tb_jk_cmd_sequencer;
    logic       clk;
    logic       clr;
    logic [3:0] J, K, shadow_q;
    logic       done, busy;
    int         errors = 0;
    int         checks = 0;

    jk_cmd_sequencer_if #(.WIDTH(4), .CNT_W(4)) cmd_if ();

    jk_cmd_sequencer #(.WIDTH(4), .DEPTH(4), .CNT_W(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .cmd      (cmd_if),
        .J        (J),
        .K        (K),
        .shadow_q (shadow_q),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [3:0] mask, input logic [3:0] rep);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_mask  = mask;
        cmd_if.cmd_rep   = rep;
    endtask

    task automatic do_reset();
        cmd_if.cmd_valid = 1'b0;
        clr = 1'b0;
        step();
        step();
        clr = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clr = 1'b0;
        drive(2'b10, 4'b1111, 4'd0);
        step();
        step();
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", cmd_if.cmd_ready); end
        checks++; if ({J, K} !== 8'h00) begin errors++; $display("[TB] FAIL reset_jk: got %b/%b expected 0000/0000", J, K); end
        checks++; if (shadow_q !== 4'b0000) begin errors++; $display("[TB] FAIL reset_shadow: got %b expected 0000", shadow_q); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        cmd_if.cmd_valid = 1'b0;
        clr = 1'b1;
        step();
        step();
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", cmd_if.cmd_ready); end
        checks++; if ({busy, J, K} !== 9'h000) begin errors++; $display("[TB] FAIL release_nothing_queued: got busy=%b J=%b K=%b expected 0/0000/0000", busy, J, K); end
    endtask

    task automatic test_set();
        drive(2'b10, 4'b0101, 4'd0);
        step();
        cmd_if.cmd_valid = 1'b0;
        checks++; if ({J, K, busy} !== 9'b0000_0000_1) begin errors++; $display("[TB] FAIL set_latency: got J=%b K=%b busy=%b expected 0000/0000/1", J, K, busy); end
        step();
        checks++; if ({J, K} !== 8'b0101_0000) begin errors++; $display("[TB] FAIL set_jk: got %b/%b expected 0101/0000", J, K); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL set_done: got %b expected 1", done); end
        checks++; if (shadow_q !== 4'b0000) begin errors++; $display("[TB] FAIL set_shadow_early: got %b expected 0000", shadow_q); end
        step();
        checks++; if ({J, K, done, busy} !== 10'b0) begin errors++; $display("[TB] FAIL set_idle: got J=%b K=%b done=%b busy=%b expected all 0", J, K, done, busy); end
        checks++; if (shadow_q !== 4'b0101) begin errors++; $display("[TB] FAIL set_shadow: got %b expected 0101", shadow_q); end
        step();
        checks++; if (shadow_q !== 4'b0101) begin errors++; $display("[TB] FAIL set_shadow_hold: got %b expected 0101", shadow_q); end
    endtask

    task automatic test_toggle_repeat();
        logic [3:0] exp_sh [3];
        exp_sh[0] = 4'b0000; exp_sh[1] = 4'b1111; exp_sh[2] = 4'b0000;
        do_reset();
        drive(2'b11, 4'b1111, 4'd2);
        step();
        cmd_if.cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if ({J, K} !== 8'hFF) begin errors++; $display("[TB] FAIL toggle_jk[%0d]: got %b/%b expected 1111/1111", c, J, K); end
            checks++; if (done !== (c == 2)) begin errors++; $display("[TB] FAIL toggle_done[%0d]: got %b expected %b", c, done, (c == 2)); end
            checks++; if (shadow_q !== exp_sh[c]) begin errors++; $display("[TB] FAIL toggle_shadow[%0d]: got %b expected %b", c, shadow_q, exp_sh[c]); end
        end
        step();
        checks++; if ({J, K, busy} !== 9'b0) begin errors++; $display("[TB] FAIL toggle_end: got J=%b K=%b busy=%b expected 0", J, K, busy); end
        checks++; if (shadow_q !== 4'b1111) begin errors++; $display("[TB] FAIL toggle_shadow_final: got %b expected 1111", shadow_q); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_jk [3];
        exp_jk[0] = 8'b1111_0000; exp_jk[1] = 8'b0000_0011; exp_jk[2] = 8'b1000_1000;
        do_reset();
        drive(2'b10, 4'b1111, 4'd0);
        step();
        drive(2'b01, 4'b0011, 4'd0);
        step();
        checks++; if ({J, K} !== exp_jk[0]) begin errors++; $display("[TB] FAIL b2b_jk[0]: got %b expected %b", {J, K}, exp_jk[0]); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done[0]: got %b expected 1", done); end
        drive(2'b11, 4'b1000, 4'd0);
        step();
        cmd_if.cmd_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            checks++; if ({J, K} !== exp_jk[c]) begin errors++; $display("[TB] FAIL b2b_jk[%0d]: got %b expected %b", c, {J, K}, exp_jk[c]); end
            checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done[%0d]: got %b expected 1", c, done); end
            step();
        end
        checks++; if ({J, K, done, busy} !== 10'b0) begin errors++; $display("[TB] FAIL b2b_idle: got J=%b K=%b done=%b busy=%b expected 0", J, K, done, busy); end
        checks++; if (shadow_q !== 4'b0100) begin errors++; $display("[TB] FAIL b2b_shadow: got %b expected 0100", shadow_q); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_jk [5];
        logic [3:0] exp_sh [5];
        exp_jk[0] = 8'b0010_0000; exp_jk[1] = 8'b0000_0001; exp_jk[2] = 8'b0100_0100;
        exp_jk[3] = 8'b1000_0000; exp_jk[4] = 8'b0000_1111;
        exp_sh[0] = 4'b0001; exp_sh[1] = 4'b0011; exp_sh[2] = 4'b0010;
        exp_sh[3] = 4'b0110; exp_sh[4] = 4'b1110;
        do_reset();
        drive(2'b10, 4'b0001, 4'd15);
        step();
        drive(2'b10, 4'b0010, 4'd0);
        step();
        drive(2'b01, 4'b0001, 4'd0);
        step();
        drive(2'b11, 4'b0100, 4'd0);
        step();
        drive(2'b10, 4'b1000, 4'd0);
        step();
        drive(2'b01, 4'b1111, 4'd0);
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_6th: got %b expected 0", cmd_if.cmd_ready); end
        for (int e = 5; e <= 16; e++) begin
            step();
            checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ready_hold[%0d]: got %b expected 0", e, cmd_if.cmd_ready); end
            checks++; if (done !== (e == 16)) begin errors++; $display("[TB] FAIL full_cmd0_done[%0d]: got %b expected %b", e, done, (e == 16)); end
        end
        step();
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL full_ready_free: got %b expected 1", cmd_if.cmd_ready); end
        for (int i = 0; i < 5; i++) begin
            checks++; if ({J, K} !== exp_jk[i]) begin errors++; $display("[TB] FAIL full_order_jk[%0d]: got %b expected %b", i, {J, K}, exp_jk[i]); end
            checks++; if (shadow_q !== exp_sh[i]) begin errors++; $display("[TB] FAIL full_order_shadow[%0d]: got %b expected %b", i, shadow_q, exp_sh[i]); end
            step();
            if (i == 0) cmd_if.cmd_valid = 1'b0;
        end
        checks++; if ({J, K, busy} !== 9'b0) begin errors++; $display("[TB] FAIL full_idle: got J=%b K=%b busy=%b expected 0", J, K, busy); end
        checks++; if (shadow_q !== 4'b0000) begin errors++; $display("[TB] FAIL full_shadow_final: got %b expected 0000", shadow_q); end
    endtask

    task automatic test_reset_mid_apply();
        do_reset();
        drive(2'b11, 4'b1111, 4'd9);
        step();
        drive(2'b10, 4'b1111, 4'd0);
        step();
        drive(2'b10, 4'b0011, 4'd0);
        step();
        cmd_if.cmd_valid = 1'b0;
        step();
        step();
        checks++; if ({J, K, busy} !== 9'b1111_1111_1) begin errors++; $display("[TB] FAIL mid_active: got J=%b K=%b busy=%b expected 1111/1111/1", J, K, busy); end
        clr = 1'b0;
        step();
        checks++; if ({J, K} !== 8'h00) begin errors++; $display("[TB] FAIL mid_jk: got %b/%b expected 0000/0000", J, K); end
        checks++; if ({shadow_q, busy, done} !== 6'b0) begin errors++; $display("[TB] FAIL mid_state: got shadow=%b busy=%b done=%b expected 0000/0/0", shadow_q, busy, done); end
        clr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++; if ({J, K, shadow_q, busy} !== 13'b0) begin errors++; $display("[TB] FAIL mid_no_replay[%0d]: got J=%b K=%b shadow=%b busy=%b expected 0", c, J, K, shadow_q, busy); end
        end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_mask  = 4'b0000;
        cmd_if.cmd_rep   = 4'd0;
        clr = 1'b0;
        test_reset();
        test_set();
        test_toggle_repeat();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_apply();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
